// File: rtl/gige_pkg.sv
// Shared constants for the GbE receive frame checker: CRC-32 constants,
// preamble/SFD byte values, status bit positions and the FSM state encoding.
package gige_pkg;

  localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;
  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;

  localparam int ST_CRC_ERR  = 0;
  localparam int ST_PHY_ERR  = 1;
  localparam int ST_RUNT     = 2;
  localparam int ST_TOO_LONG = 3;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PREAMBLE = 2'd1,
    S_DATA     = 2'd2,
    S_DROP     = 2'd3
  } state_t;

endpackage

// File: rtl/gige_rx_frame_checker_if.sv
// Byte-stream bundle between the GMII RX pipeline and the frame checker.
// The checker takes the slave view; the upstream source takes the master view.
interface gige_rx_frame_checker_if;
  logic        in_en;
  logic [7:0]  in_d;
  logic        in_er;
  logic        in_frame_end;
  logic        out_valid;
  logic [7:0]  out_d;
  logic        out_sof;
  logic        out_eof;
  logic [3:0]  out_status;
  logic [15:0] out_len;

  modport master (
    output in_en, in_d, in_er, in_frame_end,
    input  out_valid, out_d, out_sof, out_eof, out_status, out_len
  );

  modport slave (
    input  in_en, in_d, in_er, in_frame_end,
    output out_valid, out_d, out_sof, out_eof, out_status, out_len
  );
endinterface

// File: rtl/crc32_d8.sv
// One byte step of the reflected IEEE 802.3 CRC-32 (LSB-first), purely combinational.
module crc32_d8
  import gige_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  d,
  output logic [31:0] crc_out
);

  logic [31:0] c;

  always_comb begin
    c = crc_in ^ {24'h000000, d};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/gige_rx_frame_checker.sv
// GbE RX frame checker: strips preamble/SFD, forwards frame bytes with sof/eof,
// checks FCS, PHY errors and length. Define GIGE_RX_STATS_EN for the frame counters.
module gige_rx_frame_checker
  import gige_pkg::*;
#(
  parameter int unsigned MAX_LEN = 1522,
  parameter int unsigned MIN_LEN = 64
) (
  input  logic                    clock,
  input  logic                    reset_n,
  gige_rx_frame_checker_if.slave  rx,
  output logic [31:0]             stat_good,
  output logic [31:0]             stat_bad
);

  localparam logic [15:0] MIN_L = 16'(MIN_LEN);
  localparam logic [15:0] MAX_L = 16'(MAX_LEN);

  state_t      state_q, state_d;
  logic [31:0] crc_q, crc_d, crc_step;
  logic [15:0] len_q, len_d, len_inc;
  logic        phy_q, phy_d, phy_acc;
  logic        out_valid_q, out_valid_d;
  logic [7:0]  out_d_q, out_d_d;
  logic        out_sof_q, out_sof_d;
  logic        out_eof_q, out_eof_d;
  logic [3:0]  out_status_q, out_status_d;
  logic [15:0] out_len_q, out_len_d;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  crc32_d8 u_crc (.crc_in(crc_q), .d(rx.in_d), .crc_out(crc_step));

  assign len_inc = sat_inc16(len_q);
  // PHY error tracking restarts with the first byte of each frame (seen in IDLE).
  assign phy_acc = ((state_q == S_IDLE) ? 1'b0 : phy_q) | rx.in_er;

  always_comb begin
    state_d      = state_q;
    crc_d        = crc_q;
    len_d        = len_q;
    phy_d        = phy_q;
    out_valid_d  = 1'b0;
    out_d_d      = 8'h00;
    out_sof_d    = 1'b0;
    out_eof_d    = 1'b0;
    out_status_d = 4'h0;
    out_len_d    = 16'h0000;
    if (rx.in_en) begin
      phy_d = phy_acc;
      case (state_q)
        S_IDLE: state_d = (rx.in_d == PREAMBLE_BYTE) ? S_PREAMBLE : S_DROP;
        S_PREAMBLE: begin
          if (rx.in_d == SFD_BYTE) begin
            state_d = S_DATA;
            crc_d   = CRC_INIT;
            len_d   = 16'h0000;
          end else if (rx.in_d != PREAMBLE_BYTE) begin
            state_d = S_DROP;
          end
        end
        S_DATA: begin
          crc_d       = crc_step;
          len_d       = len_inc;
          out_valid_d = 1'b1;
          out_d_d     = rx.in_d;
          out_sof_d   = (len_q == 16'h0000);
          out_eof_d   = rx.in_frame_end;
          if (rx.in_frame_end) begin
            out_status_d[ST_CRC_ERR]  = (crc_step != CRC_RESIDUE);
            out_status_d[ST_PHY_ERR]  = phy_acc;
            out_status_d[ST_RUNT]     = (len_inc < MIN_L);
            out_status_d[ST_TOO_LONG] = (len_inc > MAX_L);
            out_len_d                 = len_inc;
          end
        end
        default: ;
      endcase
      if (rx.in_frame_end) state_d = S_IDLE;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      crc_q        <= CRC_INIT;
      len_q        <= 16'h0000;
      phy_q        <= 1'b0;
      out_valid_q  <= 1'b0;
      out_d_q      <= 8'h00;
      out_sof_q    <= 1'b0;
      out_eof_q    <= 1'b0;
      out_status_q <= 4'h0;
      out_len_q    <= 16'h0000;
    end else begin
      state_q      <= state_d;
      crc_q        <= crc_d;
      len_q        <= len_d;
      phy_q        <= phy_d;
      out_valid_q  <= out_valid_d;
      out_d_q      <= out_d_d;
      out_sof_q    <= out_sof_d;
      out_eof_q    <= out_eof_d;
      out_status_q <= out_status_d;
      out_len_q    <= out_len_d;
    end
  end

  assign rx.out_valid  = out_valid_q;
  assign rx.out_d      = out_d_q;
  assign rx.out_sof    = out_sof_q;
  assign rx.out_eof    = out_eof_q;
  assign rx.out_status = out_status_q;
  assign rx.out_len    = out_len_q;

`ifdef GIGE_RX_STATS_EN
  logic        frame_close, good_evt;
  logic [31:0] good_q, good_d, bad_q, bad_d;

  // A frame is good only if it closed in DATA with a clean status.
  assign frame_close = rx.in_en & rx.in_frame_end;
  assign good_evt    = frame_close & (state_q == S_DATA) & (out_status_d == 4'h0);
  assign good_d      = (good_evt && good_q != 32'hFFFFFFFF) ? good_q + 32'd1 : good_q;
  assign bad_d       = (frame_close && !good_evt && bad_q != 32'hFFFFFFFF) ? bad_q + 32'd1 : bad_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      good_q <= 32'h0;
      bad_q  <= 32'h0;
    end else begin
      good_q <= good_d;
      bad_q  <= bad_d;
    end
  end

  assign stat_good = good_q;
  assign stat_bad  = bad_q;
`else
  assign stat_good = 32'h0;
  assign stat_bad  = 32'h0;
`endif

endmodule

// File: tb/tb_gige_rx_frame_checker.sv
// Directed bench for gige_rx_frame_checker: expected outputs are queued per driven
// cycle and compared one cycle later; frame counters follow GIGE_RX_STATS_EN.
module tb_gige_rx_frame_checker;
  import gige_pkg::*;

  typedef struct packed {
    logic        all;
    logic        v;
    logic [7:0]  d;
    logic        sof;
    logic        eof;
    logic [3:0]  st;
    logic [15:0] len;
  } exp_t;

`ifdef GIGE_RX_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam int TB_MIN = 64;
  localparam int TB_MAX = 1522;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] stat_good, stat_bad;
  int          checks = 0;
  int          errors = 0;
  int          exp_good = 0;
  int          exp_bad = 0;
  exp_t        sb_q[$];
  logic [7:0]  frm[$];

  gige_rx_frame_checker_if rx();

  gige_rx_frame_checker #(.MAX_LEN(TB_MAX), .MIN_LEN(TB_MIN)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .rx       (rx),
    .stat_good(stat_good),
    .stat_bad (stat_bad)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out();
    exp_t e;
    e = sb_q.pop_front();
    chk("out_valid", 32'(rx.out_valid), 32'(e.v));
    chk("out_sof", 32'(rx.out_sof), 32'(e.sof));
    chk("out_eof", 32'(rx.out_eof), 32'(e.eof));
    if (e.v || e.all) chk("out_d", 32'(rx.out_d), 32'(e.d));
    if (e.eof || e.all) begin
      chk("out_status", 32'(rx.out_status), 32'(e.st));
      chk("out_len", 32'(rx.out_len), 32'(e.len));
    end
  endtask

  task automatic step(input logic en, input logic [7:0] d, input logic er, input logic fe,
                      input logic rst_n, input exp_t e);
    rx.in_en        = en;
    rx.in_d         = d;
    rx.in_er        = er;
    rx.in_frame_end = fe;
    reset_n         = rst_n;
    sb_q.push_back(e);
    @(posedge clock);
    #1;
    check_out();
  endtask

  task automatic chk_stats(input string tag);
    chk({tag, "_stat_good"}, stat_good, 32'(exp_good));
    chk({tag, "_stat_bad"}, stat_bad, 32'(exp_bad));
  endtask

  function automatic logic [31:0] crc_ref(input int cnt);
    logic [31:0] c = 32'hFFFFFFFF;
    for (int i = 0; i < cnt; i++) begin
      c = c ^ {24'h000000, frm[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  // n data bytes after SFD (FCS included when fcs=1); indices are 0-based, -1 disables.
  task automatic send_frame(input string tag, input int n, input bit fcs, input int flip,
                            input int er, input int bad_pre, input int rst_at, input bit gaps);
    logic [31:0] fcs_v;
    logic [7:0]  b;
    logic [3:0]  st;
    bit          dropped;
    int          npay;
    exp_t        e;
    frm.delete();
    npay = fcs ? n - 4 : n;
    for (int i = 0; i < npay; i++) begin
      b = 8'((i * 37 + 11) & 255);
      if (b == 8'h55) b = 8'h5A;
      frm.push_back(b);
    end
    if (fcs) begin
      fcs_v = ~crc_ref(npay);
      for (int k = 0; k < 4; k++) frm.push_back(fcs_v[8*k +: 8]);
    end
    if (flip >= 0) frm[flip] = frm[flip] ^ 8'h01;
    st = 4'h0;
    st[ST_CRC_ERR]  = !fcs || (flip >= 0);
    st[ST_PHY_ERR]  = (er >= 0);
    st[ST_RUNT]     = (n < TB_MIN);
    st[ST_TOO_LONG] = (n > TB_MAX);
    dropped = (bad_pre >= 0);
    for (int i = 0; i < 7; i++) begin
      e = '0;
      step(1'b1, (i == bad_pre) ? 8'h00 : 8'h55, 1'b0, 1'b0, 1'b1, e);
    end
    e = '0;
    step(1'b1, 8'hD5, 1'b0, 1'b0, 1'b1, e);
    for (int j = 0; j < n; j++) begin
      if (gaps) begin
        e = '0;
        step(1'b0, 8'hD5, 1'b0, 1'b0, 1'b1, e);
      end
      e = '0;
      if (j == rst_at) begin
        e.all   = 1'b1;
        dropped = 1'b1;
        step(1'b1, frm[j], 1'b0, 1'b0, 1'b0, e);
        exp_good = 0;
        exp_bad  = 0;
        chk_stats({tag, "_rst"});
      end else begin
        if (!dropped) begin
          e.v   = 1'b1;
          e.d   = frm[j];
          e.sof = (j == 0);
          e.eof = (j == n - 1);
          if (j == n - 1) begin
            e.st  = st;
            e.len = 16'(n);
          end
        end
        step(1'b1, frm[j], (j == er), (j == n - 1), 1'b1, e);
      end
    end
    if (STATS) begin
      if (dropped || st != 4'h0) exp_bad++;
      else exp_good++;
    end
    chk_stats(tag);
  endtask

  initial begin
    exp_t e;
    rx.in_en        = 1'b0;
    rx.in_d         = 8'h00;
    rx.in_er        = 1'b0;
    rx.in_frame_end = 1'b0;
    reset_n         = 1'b0;
    e     = '0;
    e.all = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, e);
    step(1'b1, 8'h55, 1'b1, 1'b1, 1'b0, e);
    chk_stats("reset");

    send_frame("good64", 64, 1'b1, -1, -1, -1, -1, 1'b0);
    send_frame("crc_flip", 64, 1'b1, 19, -1, -1, -1, 1'b0);
    send_frame("phy_runt60", 60, 1'b1, -1, 9, -1, -1, 1'b0);
    send_frame("bad_pre", 64, 1'b1, -1, -1, 2, -1, 1'b0);
    send_frame("after_bad_pre", 64, 1'b1, -1, -1, -1, -1, 1'b0);
    send_frame("long1530", 1530, 1'b1, -1, -1, -1, -1, 1'b0);
    send_frame("mid_reset", 64, 1'b1, -1, -1, -1, 29, 1'b0);
    send_frame("after_reset", 64, 1'b1, -1, -1, -1, -1, 1'b0);
    send_frame("max1522", 1522, 1'b1, -1, -1, -1, -1, 1'b0);
    send_frame("over1523", 1523, 1'b1, -1, -1, -1, -1, 1'b0);
    send_frame("runt63", 63, 1'b1, -1, -1, -1, -1, 1'b0);
    send_frame("single", 1, 1'b0, -1, -1, -1, -1, 1'b0);
    send_frame("gaps", 64, 1'b1, -1, -1, -1, -1, 1'b1);

    // SFD carrying frame_end: no DATA bytes, frame counts as bad
    e = '0;
    step(1'b1, 8'h55, 1'b0, 1'b0, 1'b1, e);
    step(1'b1, 8'hD5, 1'b0, 1'b1, 1'b1, e);
    if (STATS) exp_bad++;
    chk_stats("zero_data");
    send_frame("after_zero", 64, 1'b1, -1, -1, -1, -1, 1'b0);

    e = '0;
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, e);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, e);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gige_rx_frame_checker.md
GIGE_RX_FRAME_CHECKER -- requirements
Module: gige_rx_frame_checker

Interface
REQ-001 Parameter: MAX_LEN, 1522, largest byte count (post-SFD, incl. FCS) not flagged too-long.
REQ-002 Parameter: MIN_LEN, 64, smallest byte count not flagged runt.
REQ-003 clock  in  1  single clock; all logic on rising edge.
REQ-004 reset_n  in  1  reset, synchronous, active-low.
REQ-005 in_en  in  1  byte strobe from GMII RX pipeline.
REQ-006 in_d  in  8  received byte, valid when in_en=1.
REQ-007 in_er  in  1  PHY error for the current byte.
REQ-008 in_frame_end  in  1  marks last byte of a frame; only asserted with in_en=1.
REQ-009 out_valid  out  1  out_d carries a frame byte (post-SFD, FCS included).
REQ-010 out_d  out  8  frame byte.
REQ-011 out_sof  out  1  first byte after SFD; only with out_valid.
REQ-012 out_eof  out  1  last byte of frame; only with out_valid.
REQ-013 out_status  out  4  valid on out_eof: [0] crc_err, [1] phy_err, [2] runt, [3] too_long.
REQ-014 out_len  out  16  byte count of frame, valid on out_eof, saturates at 0xFFFF.
REQ-015 stat_good  out  32  good-frame counter (see Configuration).
REQ-016 stat_bad  out  32  bad/dropped-frame counter (see Configuration).

Function
REQ-017 FSM states IDLE, PREAMBLE, DATA, DROP; one transition per in_en byte; in_frame_end=1 forces next state IDLE from any state.
REQ-018 IDLE: byte 0x55 -> PREAMBLE; any other byte -> DROP.
REQ-019 PREAMBLE: 0x55 -> stay; 0xD5 -> DATA; any other byte -> DROP.
REQ-020 DATA: each in_en byte forwarded; out_valid/out_d/out_sof/out_eof registered, latency exactly 1 cycle from input byte.
REQ-021 out_sof on first DATA byte; out_eof on the byte carrying in_frame_end; single-byte frame asserts both.
REQ-022 CRC-32 IEEE 802.3, reflected, init 0xFFFFFFFF, over all DATA bytes incl. FCS; crc_err=1 unless register after last byte equals 0xDEBB20E3.
REQ-023 Status computed including the last byte, presented same cycle as out_eof.
REQ-024 phy_err sticky: set if in_er=1 on any byte from first byte through frame end (preamble included).
REQ-025 runt if out_len < MIN_LEN; too_long if out_len > MAX_LEN; too-long frames still forwarded in full.
REQ-026 in_en low inside a frame: no state change, no output.
REQ-027 Frame ending in IDLE/PREAMBLE/DROP, or in DATA with zero bytes: no output bytes, counted bad.
REQ-028 Frame good iff out_status==0 at out_eof.
REQ-029 Back-to-back frames with zero idle cycles between frame_end and next byte handled; CRC, length, status reset on entry to DATA.

Reset
REQ-030 reset_n=0 at a clock edge: FSM->IDLE; all outputs 0; CRC=0xFFFFFFFF; length 0; counters 0.
REQ-031 Reset mid-frame abandons the frame with no out_eof; remainder of that frame is dropped via IDLE->DROP.

Configuration
REQ-032 Macro GIGE_RX_STATS_EN defined: stat_good/stat_bad increment by 1 per completed frame per REQ-027/028, saturating at 0xFFFFFFFF.
REQ-033 Macro not defined: counter logic absent; stat_good and stat_bad tied to 0.

Structure
REQ-034 Shared package gige_pkg: CRC polynomial 0xEDB88320, residue 0xDEBB20E3, PREAMBLE 0x55, SFD 0xD5, status bit indices, FSM state encoding.
REQ-035 One sub-module crc32_d8: combinational 8-bit-per-step CRC next-state function (crc_in, d -> crc_out).

Verification
REQ-036 7x0x55, 0xD5, 64-byte valid frame -> 64 out_valid, sof on byte 1, eof on byte 64, status 0, len 64, stat_good=1.
REQ-037 Same frame, payload byte 20 XOR 0x01 -> status 0x1, stat_bad=1.
REQ-038 Valid 60-byte frame, in_er on byte 10 -> status 0x6 (phy_err, runt).
REQ-039 Preamble byte 3 = 0x00 -> no out_valid for whole frame, stat_bad+1; next good frame back-to-back fully forwarded, status 0.
REQ-040 1530-byte valid frame -> all 1530 bytes forwarded, status 0x8, len 1530.
REQ-041 reset_n low for 1 cycle at DATA byte 30 -> outputs 0 next cycle, no eof, remaining bytes dropped, following frame good.
